// File: rtl/relay_logic_unit.sv
// relay_logic_unit: sequential relay ALU with a settle-time model.
// Computes one of eight Harry-Porter ALU functions on operands B and C. The
// result is presented SETTLE_CYCLES clocks after the request is accepted, and
// it is held behind a valid/ready handshake.
// Optional feature: define RELAY_LU_OVF_EN to add the 'overflow' output. This
// output carries signed overflow for ADD and INC.
module relay_logic_unit #(
    parameter int WIDTH         = 8,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [2:0]       func,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    output logic             result_valid,
    input  logic             result_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             sign,
    output logic             carry
`ifdef RELAY_LU_OVF_EN
    ,
    output logic             overflow
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        FN_ADD = 3'b000,
        FN_INC = 3'b001,
        FN_AND = 3'b010,
        FN_OR  = 3'b011,
        FN_XOR = 3'b100,
        FN_NOT = 3'b101,
        FN_SHL = 3'b110,
        FN_CLR = 3'b111
    } func_t;

    // A settle of one cycle still needs a 1-bit counter that holds zero.
    localparam int              CNT_W    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [WIDTH:0]   ONE_EXT  = (WIDTH + 1)'(1);
`ifdef RELAY_LU_OVF_EN
    // INC overflows only when it steps from the largest positive value.
    localparam logic [WIDTH-1:0] INC_OVF_PAT = {1'b0, {(WIDTH - 1){1'b1}}};
`endif

    state_t           state_q, state_d;
    logic [CNT_W-1:0] settleCnt_q, settleCnt_d;
    func_t            func_q;
    logic [WIDTH-1:0] operandB_q, operandC_q;

    logic             accept;
    logic             loadResult;

    logic [WIDTH:0]   addSum;
    logic [WIDTH:0]   incSum;
    logic [WIDTH-1:0] aluResult;
    logic             aluCarry;

    logic [WIDTH-1:0] result_q;
    logic             zero_q, sign_q, carry_q;

`ifdef RELAY_LU_OVF_EN
    logic             aluOverflow;
    logic             overflow_q;
`endif

    // State register. Reset returns the unit to IDLE from any state, including mid-settle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and handshake outputs. Ready appears only in IDLE and valid only in DONE.
    always_comb begin
        state_d      = state_q;
        op_ready     = 1'b0;
        result_valid = 1'b0;
        accept       = 1'b0;
        loadResult   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                op_ready = 1'b1;
                if (op_valid) begin
                    accept  = 1'b1;
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (settleCnt_q == '0) begin
                    loadResult = 1'b1;
                    state_d    = ST_DONE;
                end
            end
            ST_DONE: begin
                result_valid = 1'b1;
                if (result_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Settle counter. It loads on accept and counts down to zero while the relays settle.
    always_comb begin
        settleCnt_d = settleCnt_q;
        if (accept) begin
            settleCnt_d = CNT_LOAD;
        end else if ((state_q == ST_SETTLE) && (settleCnt_q != '0)) begin
            settleCnt_d = settleCnt_q - CNT_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            settleCnt_q <= '0;
        end else begin
            settleCnt_q <= settleCnt_d;
        end
    end

    // Capture the request on accept. Later changes on the bus cannot disturb this operation.
    always_ff @(posedge clk) begin
        if (reset) begin
            func_q     <= FN_ADD;
            operandB_q <= '0;
            operandC_q <= '0;
        end else if (accept) begin
            func_q     <= func_t'(func);
            operandB_q <= b;
            operandC_q <= c;
        end
    end

    // Function unit working on the captured operands. All arithmetic is modulo 2^WIDTH.
    always_comb begin
        addSum    = {1'b0, operandB_q} + {1'b0, operandC_q};
        incSum    = {1'b0, operandB_q} + ONE_EXT;
        aluResult = '0;
        aluCarry  = 1'b0;
`ifdef RELAY_LU_OVF_EN
        aluOverflow = 1'b0;
`endif
        case (func_q)
            FN_ADD: begin
                aluResult = addSum[WIDTH-1:0];
                aluCarry  = addSum[WIDTH];
`ifdef RELAY_LU_OVF_EN
                aluOverflow = (operandB_q[WIDTH-1] == operandC_q[WIDTH-1]) &&
                              (addSum[WIDTH-1] != operandB_q[WIDTH-1]);
`endif
            end
            FN_INC: begin
                aluResult = incSum[WIDTH-1:0];
                aluCarry  = incSum[WIDTH];
`ifdef RELAY_LU_OVF_EN
                aluOverflow = (operandB_q == INC_OVF_PAT);
`endif
            end
            FN_AND: aluResult = operandB_q & operandC_q;
            FN_OR:  aluResult = operandB_q | operandC_q;
            FN_XOR: aluResult = operandB_q ^ operandC_q;
            FN_NOT: aluResult = ~operandB_q;
            FN_SHL: begin
                aluResult = {operandB_q[WIDTH-2:0], operandB_q[WIDTH-1]};
                aluCarry  = operandB_q[WIDTH-1];
            end
            FN_CLR: aluResult = '0;
            default: aluResult = '0;
        endcase
    end

    // Result and flag registers. They update only on the SETTLE->DONE edge and hold otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            result_q <= '0;
            zero_q   <= 1'b0;
            sign_q   <= 1'b0;
            carry_q  <= 1'b0;
        end else if (loadResult) begin
            result_q <= aluResult;
            zero_q   <= (aluResult == '0);
            sign_q   <= aluResult[WIDTH-1];
            carry_q  <= aluCarry;
        end
    end

`ifdef RELAY_LU_OVF_EN
    // Overflow flag register. It shares the update timing of the other flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow_q <= 1'b0;
        end else if (loadResult) begin
            overflow_q <= aluOverflow;
        end
    end

    assign overflow = overflow_q;
`endif

    assign result = result_q;
    assign zero   = zero_q;
    assign sign   = sign_q;
    assign carry  = carry_q;

endmodule
